// File: rtl/axi_write_data_receiver.sv
// axi_write_data_receiver
// Responder end of the AXI W channel. Accepts one burst at a time (started by `go`),
// buffers beats in a small FIFO and forwards them to a local valid/ready sink.
// WID, beat count and WLAST are checked against the burst that was started.
//
// Ports:
//   clk, reset                    single clock, synchronous active-high reset
//   go, expected_id, burst_len    burst start, captured ID and AWLEN (beats - 1)
//   done, resp                    burst finished and drained; 00 OKAY / 10 SLVERR
//   err_id, err_last_early,
//   err_last_missing              sticky error flags, cleared on the next accepted go
//   WID/WDATA/WSTRB/WLAST/WVALID  W channel inputs; WREADY output
//   out_data/out_strb/out_last    head-of-FIFO beat; out_valid/out_ready handshake
//   current_state_out             FSM state encoding (000 only right after reset)
module axi_write_data_receiver #(
    parameter int unsigned data_width = 32,
    parameter int unsigned fifo_depth = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    go,
    input  logic [3:0]              expected_id,
    input  logic [7:0]              burst_len,
    output logic                    done,
    output logic [1:0]              resp,
    output logic                    err_id,
    output logic                    err_last_early,
    output logic                    err_last_missing,
    input  logic [3:0]              WID,
    input  logic [data_width-1:0]   WDATA,
    input  logic [data_width/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [data_width-1:0]   out_data,
    output logic [data_width/8-1:0] out_strb,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2:0]              current_state_out
);

    localparam int unsigned StrbW  = data_width / 8;
    localparam int unsigned PtrW   = $clog2(fifo_depth);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned EntryW = data_width + StrbW + 1;

    typedef enum logic [2:0] {
        StReset    = 3'b000,
        StIdle     = 3'b001,
        StReceive  = 3'b010,
        StDrain    = 3'b011,
        StComplete = 3'b100
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        id_q, id_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic              err_id_q, err_id_d;
    logic              err_early_q, err_early_d;
    logic              err_missing_q, err_missing_d;

    logic [EntryW-1:0] mem_q [fifo_depth];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;

    logic full, push, pop, at_len, drained;

    // WREADY depends only on registered state and occupancy.
    assign full      = (count_q == CntW'(fifo_depth));
    assign WREADY    = (state_q == StReceive) && !full;
    assign out_valid = (count_q != '0);
    assign push      = WVALID && WREADY;
    assign pop       = out_valid && out_ready;
    assign at_len    = (beat_cnt_q == len_q);
    // Empty after this edge; lets done rise two cycles after the last beat at full rate.
    assign drained   = (count_q == '0) || ((count_q == CntW'(1)) && pop);

    assign {out_last, out_strb, out_data} = mem_q[rd_ptr_q];

    assign err_id            = err_id_q;
    assign err_last_early    = err_early_q;
    assign err_last_missing  = err_missing_q;
    assign current_state_out = state_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        len_d         = len_q;
        beat_cnt_d    = beat_cnt_q;
        err_id_d      = err_id_q;
        err_early_d   = err_early_q;
        err_missing_d = err_missing_q;
        done          = 1'b0;
        resp          = 2'b00;
        case (state_q)
            StReset: state_d = StIdle;
            StIdle: begin
                if (go) begin
                    id_d          = expected_id;
                    len_d         = burst_len;
                    beat_cnt_d    = '0;
                    err_id_d      = 1'b0;
                    err_early_d   = 1'b0;
                    err_missing_d = 1'b0;
                    state_d       = StReceive;
                end
            end
            StReceive: begin
                if (push) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (WID != id_q) err_id_d = 1'b1;
                    if (at_len && !WLAST) err_missing_d = 1'b1;
                    if (WLAST && !at_len) err_early_d = 1'b1;
                    if (WLAST || at_len) state_d = StDrain;
                end
            end
            StDrain: begin
                if (drained) state_d = StComplete;
            end
            StComplete: begin
                done = 1'b1;
                resp = (err_id_q || err_early_q || err_missing_q) ? 2'b10 : 2'b00;
                if (!go) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StReset;
            id_q          <= '0;
            len_q         <= '0;
            beat_cnt_q    <= '0;
            err_id_q      <= 1'b0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            len_q         <= len_d;
            beat_cnt_q    <= beat_cnt_d;
            err_id_q      <= err_id_d;
            err_early_q   <= err_early_d;
            err_missing_q <= err_missing_d;
            count_q       <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {WLAST, WSTRB, WDATA};
    end

endmodule

// File: tb/tb_axi_write_data_receiver.sv
module tb_axi_write_data_receiver;

    logic        clk = 1'b0;
    logic        reset, go;
    logic [3:0]  expected_id;
    logic [7:0]  burst_len;
    logic        done;
    logic [1:0]  resp;
    logic        err_id, err_last_early, err_last_missing;
    logic [3:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic        out_last, out_valid, out_ready;
    logic [2:0]  current_state_out;

    int checks   = 0;
    int failures = 0;
    logic [36:0] got[$];
    logic [36:0] expq[$];

    always #5 clk = ~clk;

    axi_write_data_receiver #(.data_width(32), .fifo_depth(4)) dut (
        .clk(clk), .reset(reset), .go(go), .expected_id(expected_id), .burst_len(burst_len),
        .done(done), .resp(resp), .err_id(err_id), .err_last_early(err_last_early),
        .err_last_missing(err_last_missing), .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB),
        .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY), .out_data(out_data),
        .out_strb(out_strb), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .current_state_out(current_state_out)
    );

    // Record every beat that will pop at the coming rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) got.push_back({out_last, out_strb, out_data});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] id, input logic [7:0] len);
        expected_id = id;
        burst_len   = len;
        go          = 1'b1;
        step();
        go = 1'b0;
        got.delete();
        expq.delete();
    endtask

    task automatic push_beat(input logic [3:0] id, input logic [31:0] d, input logic [3:0] s,
                             input logic l);
        bit ok;
        ok     = 1'b0;
        WID    = id;
        WDATA  = d;
        WSTRB  = s;
        WLAST  = l;
        WVALID = 1'b1;
        for (int c = 0; c < 40 && !ok; c++) begin
            if (WREADY === 1'b1) ok = 1'b1;
            step();
        end
        WVALID = 1'b0;
        chk("beat_accepted", 64'(ok), 64'd1);
        if (ok) expq.push_back({l, s, d});
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (done === 1'b1) seen = 1'b1;
            else step();
        end
        chk("done_reached", 64'(seen), 64'd1);
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_count"}, 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++) chk(tag, 64'(got[i]), 64'(expq[i]));
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; expected_id = '0; burst_len = '0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; out_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_state", 64'(current_state_out), 64'h0);
        chk("rst_wready", 64'(WREADY), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_resp", 64'(resp), 64'h0);
        chk("rst_errs", 64'({err_id, err_last_early, err_last_missing}), 64'h0);
        reset = 1'b0;
        step();
        chk("idle_state", 64'(current_state_out), 64'h1);
        chk("idle_wready", 64'(WREADY), 64'h0);

        // Normal burst, full rate
        out_ready = 1'b1;
        start(4'd5, 8'd3);
        chk("t1_wready", 64'(WREADY), 64'h1);
        chk("t1_state_rx", 64'(current_state_out), 64'h2);
        chk("t1_out_valid0", 64'(out_valid), 64'h0);
        push_beat(4'd5, 32'h1111_0000, 4'hF, 1'b0);
        chk("t1_latency", 64'(out_valid), 64'h1);
        push_beat(4'd5, 32'h1111_0001, 4'hF, 1'b0);
        push_beat(4'd5, 32'h1111_0002, 4'hF, 1'b0);
        push_beat(4'd5, 32'h1111_0003, 4'hF, 1'b1);
        chk("t1_state_drain", 64'(current_state_out), 64'h3);
        chk("t1_done_early", 64'(done), 64'h0);
        chk("t1_out_last", 64'(out_last), 64'h1);
        step();
        chk("t1_done_n2", 64'(done), 64'h1);
        chk("t1_resp", 64'(resp), 64'h0);
        cmp_stream("t1_stream");
        step();
        chk("t1_back_idle", 64'(current_state_out), 64'h1);

        // Backpressure
        out_ready = 1'b0;
        start(4'd1, 8'd7);
        for (int i = 0; i < 4; i++) push_beat(4'd1, 32'hB0B0_0000 + 32'(i), 4'(i + 1), 1'b0);
        chk("t2_wready_full", 64'(WREADY), 64'h0);
        chk("t2_head", 64'(out_data), 64'hB0B0_0000);
        step();
        step();
        chk("t2_wready_hold", 64'(WREADY), 64'h0);
        chk("t2_head_stable", 64'(out_data), 64'hB0B0_0000);
        chk("t2_strb_stable", 64'(out_strb), 64'h1);
        chk("t2_valid_hold", 64'(out_valid), 64'h1);
        out_ready = 1'b1;
        for (int i = 4; i < 8; i++) push_beat(4'd1, 32'hB0B0_0000 + 32'(i), 4'(i + 1), i == 7);
        wait_done();
        chk("t2_resp", 64'(resp), 64'h0);
        cmp_stream("t2_stream");
        step();

        // WID mismatch, then go held high in COMPLETE
        start(4'd2, 8'd3);
        push_beat(4'd2, 32'hC000_0000, 4'h3, 1'b0);
        chk("t3_err_id_clear", 64'(err_id), 64'h0);
        push_beat(4'd3, 32'hC000_0001, 4'hC, 1'b0);
        chk("t3_err_id_set", 64'(err_id), 64'h1);
        push_beat(4'd2, 32'hC000_0002, 4'h5, 1'b0);
        push_beat(4'd2, 32'hC000_0003, 4'hA, 1'b1);
        wait_done();
        chk("t3_resp", 64'(resp), 64'h2);
        cmp_stream("t3_stream");
        go = 1'b1;
        step();
        step();
        chk("t3_go_held_state", 64'(current_state_out), 64'h4);
        chk("t3_go_held_done", 64'(done), 64'h1);
        go = 1'b0;
        step();
        chk("t3_back_idle", 64'(current_state_out), 64'h1);

        // Early WLAST
        start(4'd4, 8'd3);
        chk("t4_flags_cleared", 64'(err_id), 64'h0);
        push_beat(4'd4, 32'hD000_0000, 4'hF, 1'b0);
        push_beat(4'd4, 32'hD000_0001, 4'hF, 1'b1);
        chk("t4_state_drain", 64'(current_state_out), 64'h3);
        chk("t4_wready", 64'(WREADY), 64'h0);
        chk("t4_early", 64'(err_last_early), 64'h1);
        chk("t4_missing", 64'(err_last_missing), 64'h0);
        wait_done();
        chk("t4_resp", 64'(resp), 64'h2);
        cmp_stream("t4_stream");
        step();

        // Missing WLAST
        start(4'd6, 8'd1);
        push_beat(4'd6, 32'hE000_0000, 4'h1, 1'b0);
        push_beat(4'd6, 32'hE000_0001, 4'h2, 1'b0);
        chk("t5_missing", 64'(err_last_missing), 64'h1);
        chk("t5_early", 64'(err_last_early), 64'h0);
        chk("t5_state_drain", 64'(current_state_out), 64'h3);
        wait_done();
        chk("t5_resp", 64'(resp), 64'h2);
        cmp_stream("t5_stream");
        step();

        // Reset mid-burst, then a fresh burst
        out_ready = 1'b0;
        start(4'd7, 8'd3);
        push_beat(4'd7, 32'hF000_0000, 4'hF, 1'b0);
        push_beat(4'd7, 32'hF000_0001, 4'hF, 1'b0);
        chk("t6_pre_valid", 64'(out_valid), 64'h1);
        reset  = 1'b1;
        WVALID = 1'b1;
        step();
        chk("t6_rst_valid", 64'(out_valid), 64'h0);
        chk("t6_rst_wready", 64'(WREADY), 64'h0);
        chk("t6_rst_state", 64'(current_state_out), 64'h0);
        reset = 1'b0;
        step();
        chk("t6_idle_state", 64'(current_state_out), 64'h1);
        chk("t6_idle_valid", 64'(out_valid), 64'h0);
        WVALID    = 1'b0;
        out_ready = 1'b1;
        start(4'd8, 8'd0);
        push_beat(4'd8, 32'h5A5A_A5A5, 4'h9, 1'b1);
        wait_done();
        chk("t6_resp", 64'(resp), 64'h0);
        chk("t6_errs", 64'({err_id, err_last_early, err_last_missing}), 64'h0);
        cmp_stream("t6_stream");
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
